ddram_req_arbiter: RTL and testbench

//   Shares the single DDRAM toggle-handshake port among three requesters:
//   - cartridge ROM reads (CPU side)
//   - ROM loader writes (ioctl download)
//   - backup RAM load/save transfers (sd_buff side)
//   One command is in flight at a time. Sits between the requesters and the

---
 rtl/ddram_req_arbiter.sv | 155 +++++++++++++++
 tb/tb_ddram_req_arbiter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ddram_req_arbiter.sv
// ddram_req_arbiter
//   Shares one DDRAM toggle-handshake port among three requesters on clk_sys:
//   cartridge ROM reads (rd), ROM loader writes (ld) and backup RAM
//   load/save transfers (bk). Only one command is in flight at a time.
//   A requester is pending while its req toggle differs from its ack toggle.
//
// Ports
//   MCLK, RESET_N            system clock, synchronous active-low reset
//   rd_addr/rd_req           ROM read request; rd_ack/rd_dout return path
//   ld_addr/ld_din/ld_req    loader write request; ld_ack return toggle
//   bk_addr/bk_din/bk_we/    backup RAM read or write request;
//   bk_req                   bk_ack/bk_dout return path
//   mem_addr/mem_din/mem_we/ command to the ddram controller (toggle on mem_req)
//   mem_req
//   mem_ack/mem_dout         completion toggle and read data from the controller
module ddram_req_arbiter #(
   parameter int ADDR_W   = 24,
   parameter int MAX_WAIT = 15
) (
   input  logic              MCLK,
   input  logic              RESET_N,
   input  logic [ADDR_W-1:0] rd_addr,
   input  logic              rd_req,
   output logic              rd_ack,
   output logic [15:0]       rd_dout,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [15:0]       ld_din,
   input  logic              ld_req,
   output logic              ld_ack,
   input  logic [ADDR_W-1:0] bk_addr,
   input  logic [15:0]       bk_din,
   input  logic              bk_we,
   input  logic              bk_req,
   output logic              bk_ack,
   output logic [15:0]       bk_dout,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [15:0]       mem_din,
   output logic              mem_we,
   output logic              mem_req,
   input  logic              mem_ack,
   input  logic [15:0]       mem_dout
);

   localparam int CNT_W = $clog2(MAX_WAIT + 1);
   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);

   typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
   typedef enum logic [1:0] {SEL_RD, SEL_LD, SEL_BK} sel_t;

   state_t           state, state_next;
   sel_t             winner, grant_sel;
   logic [CNT_W-1:0] starve_cnt;
   logic             pref_bk;   // 1: bk wins the next ld/bk tie
   logic             rd_pend, ld_pend, bk_pend, lb_pend;
   logic             force_lb, pick_bk, any_pend, mem_done;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      return (c >= MAX_CNT) ? MAX_CNT : c + CNT_W'(1);
   endfunction

   always_comb begin
      rd_pend  = rd_req ^ rd_ack;
      ld_pend  = ld_req ^ ld_ack;
      bk_pend  = bk_req ^ bk_ack;
      lb_pend  = ld_pend | bk_pend;
      any_pend = rd_pend | lb_pend;
      mem_done = (mem_ack == mem_req);
      // Once rd has bypassed ld/bk MAX_WAIT times, ld/bk go first.
      force_lb = (starve_cnt == MAX_CNT) && lb_pend;
      pick_bk  = bk_pend && (!ld_pend || pref_bk);
      if (rd_pend && !force_lb)
         grant_sel = SEL_RD;
      else if (pick_bk)
         grant_sel = SEL_BK;
      else
         grant_sel = SEL_LD;

      state_next = state;
      case (state)
         IDLE:    if (any_pend) state_next = WAIT;
         WAIT:    if (mem_done) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge MCLK) begin
      if (!RESET_N)
         state <= IDLE;
      else
         state <= state_next;
   end

   always_ff @(posedge MCLK) begin
      if (!RESET_N) begin
         winner     <= SEL_RD;
         starve_cnt <= '0;
         pref_bk    <= 1'b0;
         mem_addr   <= '0;
         mem_din    <= '0;
         mem_we     <= 1'b0;
         mem_req    <= 1'b0;
         rd_ack     <= 1'b0;
         ld_ack     <= 1'b0;
         bk_ack     <= 1'b0;
         rd_dout    <= '0;
         bk_dout    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (any_pend) begin
                  winner  <= grant_sel;
                  mem_req <= ~mem_req;
                  case (grant_sel)
                     SEL_RD: begin
                        mem_addr <= rd_addr;
                        mem_we   <= 1'b0;
                        if (lb_pend) starve_cnt <= sat_inc(starve_cnt);
                     end
                     SEL_LD: begin
                        mem_addr   <= ld_addr;
                        mem_din    <= ld_din;
                        mem_we     <= 1'b1;
                        starve_cnt <= '0;
                        pref_bk    <= 1'b1;
                     end
                     default: begin
                        mem_addr   <= bk_addr;
                        mem_din    <= bk_din;
                        mem_we     <= bk_we;
                        starve_cnt <= '0;
                        pref_bk    <= 1'b0;
                     end
                  endcase
               end
            end
            WAIT: begin
               if (mem_done) begin
                  if (winner == SEL_RD) rd_dout <= mem_dout;
                  if (winner == SEL_BK && !mem_we) bk_dout <= mem_dout;
               end
            end
            DONE: begin
               case (winner)
                  SEL_RD:  rd_ack <= ~rd_ack;
                  SEL_LD:  ld_ack <= ~ld_ack;
                  default: bk_ack <= ~bk_ack;
               endcase
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ddram_req_arbiter.sv
// tb_ddram_req_arbiter
//   Directed bench for ddram_req_arbiter. A behavioural ddram controller
//   answers commands after a fixed latency from a small sparse memory
//   (unwritten words read back as addr[15:0] ^ 16'h5A5A) and logs every
//   command it receives, so grant order and command fields can be checked.
module tb_ddram_req_arbiter;

   logic        MCLK = 1'b0;
   logic        RESET_N;
   logic [23:0] rd_addr, ld_addr, bk_addr, mem_addr;
   logic        rd_req, rd_ack, ld_req, ld_ack, bk_req, bk_ack, bk_we;
   logic [15:0] rd_dout, ld_din, bk_din, bk_dout, mem_din;
   logic        mem_we, mem_req;
   logic        mem_ack = 1'b0;
   logic [15:0] mem_dout = 16'h0;

   int pass_cnt = 0;
   int total_cnt = 0;
   int lat = 5;

   logic [15:0] mem_model [logic [23:0]];
   logic [23:0] log_addr[$];
   logic        log_we[$];
   logic [15:0] log_din[$];
   bit          busy = 1'b0;
   int          cnt = 0;

   always #5 MCLK = ~MCLK;

   ddram_req_arbiter #(.ADDR_W(24), .MAX_WAIT(15)) dut (
      .MCLK(MCLK), .RESET_N(RESET_N),
      .rd_addr(rd_addr), .rd_req(rd_req), .rd_ack(rd_ack), .rd_dout(rd_dout),
      .ld_addr(ld_addr), .ld_din(ld_din), .ld_req(ld_req), .ld_ack(ld_ack),
      .bk_addr(bk_addr), .bk_din(bk_din), .bk_we(bk_we), .bk_req(bk_req),
      .bk_ack(bk_ack), .bk_dout(bk_dout),
      .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we), .mem_req(mem_req),
      .mem_ack(mem_ack), .mem_dout(mem_dout)
   );

   function automatic logic [15:0] read_model(input logic [23:0] a);
      if (mem_model.exists(a)) return mem_model[a];
      return a[15:0] ^ 16'h5A5A;
   endfunction

   // ddram controller model, evaluated on the falling edge
   always @(negedge MCLK) begin
      if (!RESET_N) begin
         mem_ack = 1'b0;
         busy    = 1'b0;
         cnt     = 0;
      end else if (mem_req != mem_ack) begin
         if (!busy) begin
            busy = 1'b1;
            cnt  = 1;
            log_addr.push_back(mem_addr);
            log_we.push_back(mem_we);
            log_din.push_back(mem_din);
         end else begin
            cnt++;
         end
         if (cnt >= lat) begin
            if (mem_we) mem_model[mem_addr] = mem_din;
            else        mem_dout = read_model(mem_addr);
            mem_ack = mem_req;
            busy    = 1'b0;
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   function automatic bit ack_done(input int w);
      case (w)
         0:       return rd_ack == rd_req;
         1:       return ld_ack == ld_req;
         default: return bk_ack == bk_req;
      endcase
   endfunction

   task automatic wait_ack(input int which, input string tag);
      bit done = 1'b0;
      for (int i = 0; i < 200 && !done; i++) begin
         @(posedge MCLK); #1;
         done = ack_done(which);
      end
      check({tag, "_timeout"}, {31'b0, done}, 32'd1);
   endtask

   task automatic cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge MCLK); #1;
      end
   endtask

   task automatic clear_log();
      log_addr.delete();
      log_we.delete();
      log_din.delete();
   endtask

   initial begin
      int order[$];
      int served;
      int rd_before;
      mem_model[24'h000100] = 16'hBEEF;
      RESET_N = 1'b0;
      rd_req = 1'b1; ld_req = 1'b0; bk_req = 1'b0; bk_we = 1'b0;
      rd_addr = '0; ld_addr = '0; bk_addr = '0; ld_din = '0; bk_din = '0;

      // 1. reset with rd_req high, then a single ROM read
      cycles(4);
      check("rst_rd_ack", {31'b0, rd_ack}, 0);
      check("rst_ld_ack", {31'b0, ld_ack}, 0);
      check("rst_bk_ack", {31'b0, bk_ack}, 0);
      check("rst_mem_req", {31'b0, mem_req}, 0);
      check("rst_mem_we", {31'b0, mem_we}, 0);
      check("rst_mem_addr", {8'b0, mem_addr}, 0);
      check("rst_mem_din", {16'b0, mem_din}, 0);
      check("rst_rd_dout", {16'b0, rd_dout}, 0);
      check("rst_bk_dout", {16'b0, bk_dout}, 0);
      rd_req = 1'b0;
      cycles(1);
      RESET_N = 1'b1;
      cycles(3);
      check("idle_mem_req", {31'b0, mem_req}, 0);
      clear_log();
      rd_addr = 24'h000100;
      rd_req  = 1'b1;
      wait_ack(0, "t1_rd");
      check("t1_rd_ack", {31'b0, rd_ack}, 1);
      check("t1_rd_dout", {16'b0, rd_dout}, 32'hBEEF);
      check("t1_cmds", log_addr.size(), 1);
      check("t1_addr", {8'b0, log_addr[0]}, 32'h100);

      // 2. all three toggled together
      clear_log();
      rd_addr = 24'h000200;
      ld_addr = 24'h000300; ld_din = 16'hCAFE;
      bk_addr = 24'h000400; bk_we  = 1'b0;
      rd_req = ~rd_req; ld_req = ~ld_req; bk_req = ~bk_req;
      wait_ack(2, "t2_bk");
      check("t2_rd_ack", {31'b0, rd_ack}, {31'b0, rd_req});
      check("t2_ld_ack", {31'b0, ld_ack}, {31'b0, ld_req});
      check("t2_cmds", log_addr.size(), 3);
      check("t2_addr0", {8'b0, log_addr[0]}, 32'h200);
      check("t2_addr1", {8'b0, log_addr[1]}, 32'h300);
      check("t2_addr2", {8'b0, log_addr[2]}, 32'h400);
      check("t2_we", {29'b0, log_we[0], log_we[1], log_we[2]}, 32'b010);
      check("t2_ld_din", {16'b0, log_din[1]}, 32'hCAFE);
      check("t2_rd_dout", {16'b0, rd_dout}, 32'h585A);
      check("t2_bk_dout", {16'b0, bk_dout}, 32'h5E5A);

      // 3. rd starves ld for exactly 15 grants
      clear_log();
      rd_addr = 24'h000600;
      ld_addr = 24'h000500; ld_din = 16'h1111;
      rd_req = ~rd_req; ld_req = ~ld_req;
      for (int i = 1; i <= 15; i++) begin
         wait_ack(0, "t3_rd");
         rd_addr = 24'h000600 + 24'(i);
         rd_req  = ~rd_req;
      end
      wait_ack(1, "t3_ld");
      wait_ack(0, "t3_rd_last");
      rd_before = 0;
      for (int i = 0; i < log_we.size() && !log_we[i]; i++) rd_before++;
      check("t3_rd_before_ld", rd_before, 15);
      check("t3_cmds", log_addr.size(), 17);
      check("t3_ld_addr", {8'b0, log_addr[15]}, 32'h500);
      check("t3_last_addr", {8'b0, log_addr[16]}, 32'h60F);
      check("t3_rd_dout", {16'b0, rd_dout}, 32'h5C55);

      // 5. reset while a command waits on the ddram
      clear_log();
      rd_addr = 24'h000800;
      rd_req  = ~rd_req;
      cycles(3);
      check("t5_inflight", {31'b0, mem_req ^ mem_ack}, 1);
      RESET_N = 1'b0;
      rd_req = 1'b0; ld_req = 1'b0; bk_req = 1'b0;
      cycles(1);
      check("t5_mem_req", {31'b0, mem_req}, 0);
      check("t5_acks", {29'b0, rd_ack, ld_ack, bk_ack}, 0);
      check("t5_rd_dout", {16'b0, rd_dout}, 0);
      RESET_N = 1'b1;
      cycles(10);
      check("t5_no_ack", {31'b0, rd_ack}, 0);
      check("t5_idle", {31'b0, mem_req}, 0);

      // 6. backup RAM write, then a ROM read after the reset
      clear_log();
      bk_we = 1'b1; bk_addr = 24'h00007F; bk_din = 16'h1234;
      bk_req = ~bk_req;
      cycles(1);
      check("t6_mem_addr", {8'b0, mem_addr}, 32'h7F);
      check("t6_mem_din", {16'b0, mem_din}, 32'h1234);
      check("t6_mem_we", {31'b0, mem_we}, 1);
      wait_ack(2, "t6_bk");
      cycles(10);
      check("t6_bk_ack", {31'b0, bk_ack}, 1);
      check("t6_cmds", log_addr.size(), 1);
      check("t6_bk_dout", {16'b0, bk_dout}, 0);
      rd_addr = 24'h000100;
      rd_req  = ~rd_req;
      wait_ack(0, "t6_rd");
      check("t6_rd_dout", {16'b0, rd_dout}, 32'hBEEF);

      // 4. ld and bk kept pending: strict alternation
      clear_log();
      ld_addr = 24'h000700; ld_din = 16'h2222;
      bk_addr = 24'h000300; bk_we  = 1'b0;
      ld_req = ~ld_req; bk_req = ~bk_req;
      served = 0;
      for (int c = 0; c < 400 && served < 4; c++) begin
         @(posedge MCLK); #1;
         if (ld_ack == ld_req) begin
            order.push_back(1); served++;
            if (served < 4) ld_req = ~ld_req;
         end else if (bk_ack == bk_req) begin
            order.push_back(2); served++;
            if (served < 4) bk_req = ~bk_req;
         end
      end
      check("t4_served", served, 4);
      for (int k = 0; k < 4; k++)
         check($sformatf("t4_order%0d", k), (k < order.size()) ? order[k] : 0, (k % 2 == 0) ? 1 : 2);
      wait_ack(1, "t4_ld_last");
      check("t4_cmds", log_addr.size(), 5);
      check("t4_addr1", {8'b0, log_addr[1]}, 32'h300);
      check("t4_we", {27'b0, log_we[0], log_we[1], log_we[2], log_we[3], log_we[4]}, 32'b10101);
      check("t4_bk_dout", {16'b0, bk_dout}, 32'hCAFE);
      check("t4_rd_dout", {16'b0, rd_dout}, 32'hBEEF);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
